// File: rtl/pakout_ser_pkg.sv
// Shared definitions for the packet-out serializer and packet-in receiver.
// Both ends derive message width and packet count from the same functions.
package pakout_ser_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int ASZ_D = 6;
  localparam int DSZ_D = 4;
  localparam int RSZ_D = 4;
  localparam int PSZ_D = 4;

  function automatic int msz_f(input int a, input int d, input int r);
    return 2 * a + d + r;
  endfunction

  function automatic int np_f(input int m, input int p);
    return (m + p - 1) / p;
  endfunction

  typedef enum logic [1:0] {
    GAP,
    SEND,
    RELEASE
  } pk_st_e;

endpackage

// File: rtl/pakout_chnl_src.sv
// 4-phase packet output channel: owns pk_req/pk_dat/pk_fst and the
// SEND/RELEASE/GAP sequencing; asks the parent for the next packet.
module pakout_chnl_src
  import pakout_ser_pkg::*;
#(
  parameter int PSZ = PSZ_D
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic           ld,
  input  logic [PSZ-1:0] ld_dat,
  input  logic [PSZ-1:0] nx_dat,
  input  logic           last,
  input  logic           pk_ack,
  output logic [PSZ-1:0] pk_dat,
  output logic           pk_fst,
  output logic           pk_req,
  output logic           adv,
  output logic           fin
);

  pk_st_e         st_q, st_d;
  logic           req_q, req_d;
  logic           fst_q, fst_d;
  logic [PSZ-1:0] dat_q, dat_d;

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      st_q  <= GAP;
      req_q <= OFF;
      fst_q <= OFF;
      dat_q <= '0;
    end else begin
      st_q  <= st_d;
      req_q <= req_d;
      fst_q <= fst_d;
      dat_q <= dat_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    req_d = req_q;
    fst_d = fst_q;
    dat_d = dat_q;
    adv   = OFF;
    fin   = OFF;
    unique case (st_q)
      GAP: begin
        // Acks seen here are spurious and deliberately ignored.
        if (ld) begin
          st_d  = SEND;
          req_d = ON;
          fst_d = ON;
          dat_d = ld_dat;
        end
      end
      SEND: begin
        if (pk_ack == ON) begin
          req_d = OFF;
          st_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (pk_ack == OFF) begin
          if (last) begin
            fin  = ON;
            st_d = GAP;
          end else begin
            adv   = ON;
            dat_d = nx_dat;
            fst_d = OFF;
            req_d = ON;
            st_d  = SEND;
          end
        end
      end
      default: st_d = GAP;
    endcase
  end

  assign pk_dat = dat_q;
  assign pk_fst = fst_q;
  assign pk_req = req_q;

endmodule

// File: rtl/pakout_ser.sv
// Message-to-packet serializer: captures {src,dst,dat,red} over 4-phase
// req/ack and emits NP packets, MSB first, on a second 4-phase channel.
module pakout_ser
  import pakout_ser_pkg::*;
#(
  parameter int ASZ = ASZ_D,
  parameter int DSZ = DSZ_D,
  parameter int RSZ = RSZ_D,
  parameter int PSZ = PSZ_D
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [ASZ-1:0] mi_src,
  input  logic [ASZ-1:0] mi_dst,
  input  logic [DSZ-1:0] mi_dat,
  input  logic [RSZ-1:0] mi_red,
  input  logic           mi_req,
  output logic           mi_ack,
  output logic [PSZ-1:0] pk_dat,
  output logic           pk_fst,
  output logic           pk_req,
  input  logic           pk_ack,
  output logic           busy
);

  localparam int MSZ = msz_f(ASZ, DSZ, RSZ);
  localparam int NP  = np_f(MSZ, PSZ);
  localparam int WSZ = NP * PSZ;
  localparam int IW  = (NP > 1) ? $clog2(NP) : 1;

  logic [WSZ-1:0] sr_q, sr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           ack_q, ack_d;

  logic [WSZ-1:0] w_ext;
  logic [WSZ-1:0] sr_sh;
  logic           cap;
  logic           last;
  logic           adv;
  logic           fin;

  assign w_ext = WSZ'({mi_src, mi_dst, mi_dat, mi_red});
  assign sr_sh = sr_q << PSZ;
  assign cap   = !busy_q && mi_req && !ack_q;
  assign last  = (idx_q == IW'(NP - 1));

  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      idx_q  <= '0;
      busy_q <= OFF;
      ack_q  <= OFF;
    end else begin
      sr_q   <= sr_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
      ack_q  <= ack_d;
    end
  end

  always_comb begin
    sr_d   = sr_q;
    idx_d  = idx_q;
    busy_d = busy_q;
    ack_d  = ack_q;
    if (cap) begin
      sr_d   = w_ext;
      idx_d  = '0;
      busy_d = ON;
      ack_d  = ON;
    end else begin
      if (adv) begin
        sr_d  = sr_sh;
        idx_d = idx_q + 1'b1;
      end
      if (fin) busy_d = OFF;
    end
    // Message-side release runs regardless of packet progress.
    if (ack_q && !mi_req) ack_d = OFF;
  end

  pakout_chnl_src #(
    .PSZ(PSZ)
  ) u_chnl (
    .i_clk  (i_clk),
    .reset  (reset),
    .ld     (cap),
    .ld_dat (w_ext[WSZ-1 -: PSZ]),
    .nx_dat (sr_sh[WSZ-1 -: PSZ]),
    .last   (last),
    .pk_ack (pk_ack),
    .pk_dat (pk_dat),
    .pk_fst (pk_fst),
    .pk_req (pk_req),
    .adv    (adv),
    .fin    (fin)
  );

  assign mi_ack = ack_q;
  assign busy   = busy_q;

endmodule
